// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: burst sequencer in front of an SPI master's SFR port.
// It takes one request, programs SPCR and SPER, asserts one slave select,
// then moves up to 16 bytes through SPDR. For each byte it polls SPIF,
// clears SPIF and returns the received byte on a valid/ready stream.
// Every output is registered except req_ready and tx_ready.
module spi_xfer_seq #(
    parameter int unsigned SS_SETUP = 2,    // spssn low cycles before first SPDR write (1..15)
    parameter int unsigned SS_HOLD  = 2,    // spssn low cycles after last byte (1..15)
    parameter int unsigned TIMEOUT  = 1023  // max SPIF poll cycles per byte
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_mode,
    input  logic [1:0] req_div,
    input  logic [2:0] req_ss,
    input  logic [3:0] req_len,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       sfrwe,
    output logic [1:0] sfraddr_w,
    output logic [2:0] sfraddr_r,
    output logic [7:0] spidata_i,
    input  logic [7:0] sfr_data_o,
    output logic [7:0] spssn_i,
    output logic       done,
    output logic       err
);

    typedef enum logic [3:0] {
        IDLE, W_CR, W_ER, SS_ON, TX_WAIT, W_DR, POLL, CLR, RD_DR, RX_OUT, SS_OFF, DONE
    } state_e;

    localparam logic [1:0] A_SPCR = 2'b00;
    localparam logic [1:0] A_SPSR = 2'b01;
    localparam logic [1:0] A_SPER = 2'b10;
    localparam logic [1:0] A_SPDR = 2'b11;
    localparam logic [2:0] R_SPSR = 3'b001;
    localparam logic [2:0] R_SPDR = 3'b011;

    // One shared counter serves setup, poll, read-latency and hold phases.
    localparam int CW = 10;

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [1:0]     div_q, div_d;
    logic [2:0]     ss_q, ss_d;
    logic [3:0]     len_q, len_d;
    logic [7:0]     tx_byte_q, tx_byte_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           rx_valid_q, rx_valid_d;
    logic           err_q, err_d;
    logic           done_q, done_d;
    logic           sfrwe_q, sfrwe_d;
    logic [1:0]     sfraddr_w_q, sfraddr_w_d;
    logic [2:0]     sfraddr_r_q, sfraddr_r_d;
    logic [7:0]     spidata_i_q, spidata_i_d;
    logic [7:0]     spssn_q, spssn_d;

    // Next-state and datapath: sequence the burst and track byte/phase counters.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        div_d      = div_q;
        ss_d       = ss_q;
        len_d      = len_q;
        tx_byte_d  = tx_byte_q;
        byte_cnt_d = byte_cnt_q;
        cnt_d      = cnt_q;
        rx_data_d  = rx_data_q;
        err_d      = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                mode_d  = req_mode;
                div_d   = req_div;
                ss_d    = req_ss;
                len_d   = req_len;
                err_d   = 1'b0;
                state_d = W_CR;
            end
            W_CR: state_d = W_ER;
            W_ER: begin
                cnt_d      = '0;
                byte_cnt_d = '0;
                state_d    = SS_ON;
            end
            SS_ON: begin
                if (cnt_q == CW'(SS_SETUP - 1)) state_d = TX_WAIT;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            TX_WAIT: if (tx_valid) begin
                tx_byte_d = tx_data;
                state_d   = W_DR;
            end
            W_DR: begin
                cnt_d   = '0;
                state_d = POLL;
            end
            POLL: begin
                if (sfr_data_o[7]) begin
                    state_d = CLR;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Abort: skip the remaining bytes and release the slave.
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = SS_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RD_DR;
            end
            RD_DR: begin
                // Read data lags the address by one cycle; sample on the second.
                if (cnt_q == CW'(1)) begin
                    rx_data_d = sfr_data_o;
                    state_d   = RX_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_OUT: if (rx_ready) begin
                // Compare before increment so the 4-bit counter never wraps.
                if (byte_cnt_q == len_q) begin
                    cnt_d   = '0;
                    state_d = SS_OFF;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    state_d    = TX_WAIT;
                end
            end
            SS_OFF: begin
                if (cnt_q == CW'(SS_HOLD - 1)) state_d = DONE;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state, so registered outputs line up with the state they belong to.
    always_comb begin
        sfrwe_d     = 1'b0;
        sfraddr_w_d = sfraddr_w_q;
        spidata_i_d = spidata_i_q;
        sfraddr_r_d = sfraddr_r_q;
        spssn_d     = spssn_q;
        case (state_d)
            W_CR: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = A_SPCR;
                spidata_i_d = {1'b0, 1'b1, 1'b0, 1'b1, mode_d, 2'b00};
            end
            W_ER: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = A_SPER;
                spidata_i_d = {6'b0, div_d};
            end
            SS_ON: spssn_d = ~(8'h01 << ss_d);
            W_DR: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = A_SPDR;
                spidata_i_d = tx_byte_d;
                // Point at SPSR early so the first poll cycle sees valid status.
                sfraddr_r_d = R_SPSR;
            end
            POLL:  sfraddr_r_d = R_SPSR;
            CLR: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = A_SPSR;
                spidata_i_d = 8'h80;
            end
            RD_DR:   sfraddr_r_d = R_SPDR;
            DONE:    spssn_d     = 8'hFF;
            default: ;
        endcase
    end

    assign rx_valid_d = (state_d == RX_OUT);
    assign done_d     = (state_d == DONE);

    // State and output registers; reset releases the slave select immediately.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            div_q       <= '0;
            ss_q        <= '0;
            len_q       <= '0;
            tx_byte_q   <= '0;
            byte_cnt_q  <= '0;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            sfrwe_q     <= 1'b0;
            sfraddr_w_q <= '0;
            sfraddr_r_q <= '0;
            spidata_i_q <= '0;
            spssn_q     <= 8'hFF;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            div_q       <= div_d;
            ss_q        <= ss_d;
            len_q       <= len_d;
            tx_byte_q   <= tx_byte_d;
            byte_cnt_q  <= byte_cnt_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            err_q       <= err_d;
            done_q      <= done_d;
            sfrwe_q     <= sfrwe_d;
            sfraddr_w_q <= sfraddr_w_d;
            sfraddr_r_q <= sfraddr_r_d;
            spidata_i_q <= spidata_i_d;
            spssn_q     <= spssn_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign tx_ready  = (state_q == TX_WAIT) && tx_valid;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign sfrwe     = sfrwe_q;
    assign sfraddr_w = sfraddr_w_q;
    assign sfraddr_r = sfraddr_r_q;
    assign spidata_i = spidata_i_q;
    assign spssn_i   = spssn_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Bench for spi_xfer_seq: SPI master/slave model on the SFR port, random tx/rx
// stream drivers, and a scoreboard of expected SFR writes and rx bytes.
module tb_spi_xfer_seq;

    localparam int SS_SETUP = 4;
    localparam int SS_HOLD  = 3;
    localparam int TIMEOUT  = 1023;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_mode = '0;
    logic [1:0] req_div = '0;
    logic [2:0] req_ss = '0;
    logic [3:0] req_len = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] tx_data = '0;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       sfrwe;
    logic [1:0] sfraddr_w;
    logic [2:0] sfraddr_r;
    logic [7:0] spidata_i;
    logic [7:0] sfr_data_o = '0;
    logic [7:0] spssn_i;
    logic       done;
    logic       err;

    spi_xfer_seq #(.SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_div(req_div), .req_ss(req_ss), .req_len(req_len),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .sfrwe(sfrwe), .sfraddr_w(sfraddr_w), .sfraddr_r(sfraddr_r),
        .spidata_i(spidata_i), .sfr_data_o(sfr_data_o), .spssn_i(spssn_i),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Scoreboard queues: expected SFR writes {addr,data}, expected rx bytes.
    logic [9:0] wr_exp[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_q[$];     // bytes the tx driver still has to hand over
    logic [7:0] reply_q[$];  // bytes the slave model shifts back

    logic [7:0] exp_ss = 8'hFF;
    bit         no_spif = 0;
    bit         gaps_en = 0;
    bit         rx_bp_en = 0;
    bit         tx_took = 0;
    bit         first_dr_seen = 0;
    int         rx_hold = 0;
    int         outstanding = 0;
    int         rx_taken = 0;
    int         done_cnt = 0;
    int         accept_cyc, cr_cyc, er_cyc, first_dr_cyc, last_dr_cyc;
    int         ss_fall_cyc, ss_rise_cyc, err_rise_cyc, done_cyc, last_rx_hs_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_tx_ready"},  tx_ready, 0);
        check({tag, "_rx_valid"},  rx_valid, 0);
        check({tag, "_rx_data"},   rx_data, 0);
        check({tag, "_sfrwe"},     sfrwe, 0);
        check({tag, "_sfraddr_w"}, sfraddr_w, 0);
        check({tag, "_sfraddr_r"}, sfraddr_r, 0);
        check({tag, "_spidata_i"}, spidata_i, 0);
        check({tag, "_spssn"},     spssn_i, 8'hFF);
        check({tag, "_done"},      done, 0);
        check({tag, "_err"},       err, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // tx stream driver: presents bytes from tx_q, optionally with random idle gaps.
    initial forever begin
        logic [7:0] sent;
        @(posedge clk); #1;
        if (!rst_n) begin
            tx_valid = 1'b0;
        end else begin
            if (tx_valid && tx_took) begin
                sent = tx_q.pop_front();
                tx_valid = 1'b0;
            end
            if (!tx_valid && tx_q.size() > 0 && (!gaps_en || $urandom_range(0, 2) == 0)) begin
                tx_valid = 1'b1;
                tx_data  = tx_q[0];
            end
        end
    end

    // rx consumer: optional forced stall, then random or constant ready.
    initial forever begin
        @(posedge clk); #1;
        if (rx_hold > 0) begin
            rx_ready = 1'b0;
            rx_hold--;
        end else begin
            rx_ready = rx_bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // SPI master + slave model: checks every SFR write, shifts a byte per SPDR
    // write, raises SPIF after a random delay and serves registered reads.
    initial begin
        logic [2:0] prev_addr;
        logic       spif;
        logic [7:0] spdr_rd;
        bit         busy;
        int         left;
        prev_addr = '0; spif = 1'b0; spdr_rd = '0; busy = 0; left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_addr = '0; spif = 1'b0; busy = 0; sfr_data_o = '0;
            end else begin
                case (prev_addr)
                    3'b001:  sfr_data_o = {spif, 7'b0};
                    3'b011:  sfr_data_o = spdr_rd;
                    default: sfr_data_o = 8'h00;
                endcase
                prev_addr = sfraddr_r;
                if (sfrwe) begin
                    check("sfr_write_expected", wr_exp.size() != 0, 1);
                    if (wr_exp.size() != 0) check("sfr_write", {sfraddr_w, spidata_i}, wr_exp.pop_front());
                    case (sfraddr_w)
                        2'b00: cr_cyc = cyc;
                        2'b10: er_cyc = cyc;
                        2'b11: begin
                            check("spdr_after_rx_taken", outstanding, 0);
                            outstanding++;
                            check("ss_at_spdr", spssn_i, exp_ss);
                            if (!first_dr_seen) begin
                                first_dr_seen = 1;
                                first_dr_cyc  = cyc;
                            end
                            last_dr_cyc = cyc;
                            busy = 1;
                            left = $urandom_range(1, 12);
                            spif = 1'b0;
                        end
                        default: if (spidata_i[7]) spif = 1'b0;
                    endcase
                end else if (busy) begin
                    if (left == 0) begin
                        busy = 0;
                        if (!no_spif) begin
                            check("slave_reply_available", reply_q.size() != 0, 1);
                            if (reply_q.size() != 0) spdr_rd = reply_q.pop_front();
                            spif = 1'b1;
                        end
                    end else begin
                        left--;
                    end
                end
            end
        end
    end

    // Monitor: pops the rx scoreboard on each handshake and watches select/done/err.
    initial begin
        logic       prev_rxv, prev_taken, prev_done, prev_err;
        logic [7:0] prev_rxd, prev_ss;
        prev_rxv = 0; prev_taken = 0; prev_done = 0; prev_err = 0; prev_rxd = '0; prev_ss = 8'hFF;
        forever begin
            @(negedge clk);
            tx_took = tx_valid && tx_ready;
            if (!rst_n) begin
                prev_rxv = 0; prev_taken = 0; prev_done = 0; prev_err = 0; prev_ss = 8'hFF;
            end else begin
                if (prev_rxv && !prev_taken && rx_valid) check("rx_stable", rx_data, prev_rxd);
                if (rx_valid && rx_ready) begin
                    check("rx_expected", rx_exp.size() != 0, 1);
                    if (rx_exp.size() != 0) check("rx_data", rx_data, rx_exp.pop_front());
                    outstanding--;
                    rx_taken++;
                    last_rx_hs_cyc = cyc;
                end
                if (spssn_i != 8'hFF) check("ss_vector", spssn_i, exp_ss);
                if (prev_ss == 8'hFF && spssn_i != 8'hFF) ss_fall_cyc = cyc;
                if (prev_ss != 8'hFF && spssn_i == 8'hFF) ss_rise_cyc = cyc;
                if (err && !prev_err) err_rise_cyc = cyc;
                if (done) begin
                    check("done_one_cycle", prev_done, 0);
                    check("ss_released_at_done", spssn_i, 8'hFF);
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_rxv = rx_valid; prev_taken = rx_valid && rx_ready; prev_rxd = rx_data;
                prev_done = done; prev_err = err; prev_ss = spssn_i;
            end
        end
    end

    // Queue the expected traffic for one burst and hand the request to the DUT.
    task automatic issue(input logic [1:0] mode, input logic [1:0] div, input logic [2:0] ss,
                         input logic [3:0] len, input bit spif_never,
                         input bit fixed, input logic [7:0] fix_tx, input logic [7:0] fix_rx);
        logic [7:0] t, r;
        int n;
        exp_ss = 8'hFF;
        exp_ss[ss] = 1'b0;
        no_spif = spif_never;
        outstanding = 0;
        rx_taken = 0;
        first_dr_seen = 0;
        wr_exp.push_back({2'b00, 8'h50 | (8'(mode) << 2)});
        wr_exp.push_back({2'b10, 6'b0, div});
        for (int i = 0; i <= int'(len); i++) begin
            t = (fixed && i == 0) ? fix_tx : 8'($urandom);
            r = (fixed && i == 0) ? fix_rx : 8'($urandom);
            tx_q.push_back(t);
            wr_exp.push_back({2'b11, t});
            if (spif_never) break;  // the first byte times out; nothing follows
            wr_exp.push_back({2'b01, 8'h80});
            reply_q.push_back(r);
            rx_exp.push_back(r);
        end
        @(posedge clk); #1;
        req_valid = 1'b1; req_mode = mode; req_div = div; req_ss = ss; req_len = len;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        check("req_accepted", req_ready, 1);
        accept_cyc = cyc;
        // Keep a junk request up while busy: it must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req_mode = 2'($urandom); req_div = 2'($urandom);
            req_ss = 3'($urandom); req_len = 4'($urandom);
            @(negedge clk);
            check("req_ready_busy", req_ready, 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err, input int budget);
        int start, n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done_cnt - start, 1);
        check("err_at_done", err, exp_err);
        repeat (4) @(negedge clk);
        check("done_once", done_cnt - start, 1);
        check("err_held", err, exp_err);
        check("ss_idle", spssn_i, 8'hFF);
        check("rx_all_received", rx_exp.size(), 0);
        check("sfr_writes_all_seen", wr_exp.size(), 0);
        check("tx_all_consumed", tx_q.size(), 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // Single byte, fixed values.
        issue(2'b00, 2'd3, 3'd0, 4'd0, 0, 1, 8'hA5, 8'h3C);
        wait_done(0, 500);
        check("single_rx_count", rx_taken, 1);

        // Full 16-byte bursts in every mode on slave 5.
        for (int m = 0; m < 4; m++) begin
            gaps_en = m[0];
            issue(2'(m), 2'(m), 3'd5, 4'd15, 0, 0, 8'h00, 8'h00);
            wait_done(0, 3000);
            check("burst16_rx_count", rx_taken, 16);
        end

        // Backpressure: long rx stall, random tx gaps and random rx_ready.
        gaps_en = 1; rx_bp_en = 1; rx_hold = 50;
        issue(2'b10, 2'd1, 3'd3, 4'd9, 0, 0, 8'h00, 8'h00);
        wait_done(0, 3000);
        check("bp_rx_count", rx_taken, 10);
        gaps_en = 0; rx_bp_en = 0;

        // Timeout: SPIF never rises; abort after the first byte.
        issue(2'b01, 2'd2, 3'd6, 4'd3, 1, 0, 8'h00, 8'h00);
        wait_done(1, 3000);
        check_range("timeout_latency", err_rise_cyc - last_dr_cyc - 1, TIMEOUT - 2, TIMEOUT + 2);
        check("timeout_done_after_hold", done_cyc - err_rise_cyc, SS_HOLD);
        check("timeout_no_rx", rx_taken, 0);
        no_spif = 0;

        // The next accepted request clears err.
        issue(2'b11, 2'd0, 3'd1, 4'd1, 0, 0, 8'h00, 8'h00);
        check("err_cleared_on_accept", err, 0);
        wait_done(0, 1000);

        // Reset in the middle of an 8-byte burst.
        issue(2'b00, 2'd1, 3'd4, 4'd7, 0, 0, 8'h00, 8'h00);
        begin
            int n = 0;
            while (rx_taken < 3 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        check("three_bytes_before_reset", rx_taken, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_reset_outputs("midburst_reset");
        tx_q.delete(); reply_q.delete(); rx_exp.delete(); wr_exp.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(2'b01, 2'd3, 3'd2, 4'd2, 0, 0, 8'h00, 8'h00);
        wait_done(0, 1000);
        check("after_reset_rx_count", rx_taken, 3);

        // Slave-select setup/hold timing with no stalls.
        issue(2'b00, 2'd0, 3'd7, 4'd2, 0, 0, 8'h00, 8'h00);
        wait_done(0, 1000);
        check("spcr_write_cycle", cr_cyc - accept_cyc, 1);
        check("sper_write_cycle", er_cyc - accept_cyc, 2);
        check("ss_fall_cycle", ss_fall_cyc - accept_cyc, 3);
        check("first_spdr_after_ss", first_dr_cyc - ss_fall_cyc, SS_SETUP + 1);
        check("ss_rise_after_last_rx", ss_rise_cyc - last_rx_hs_cyc, SS_HOLD + 1);
        check("done_with_ss_rise", done_cyc, ss_rise_cyc);

        // Random bursts.
        for (int k = 0; k < 6; k++) begin
            gaps_en = 1'($urandom_range(0, 1));
            rx_bp_en = 1'($urandom_range(0, 1));
            issue(2'($urandom), 2'($urandom), 3'($urandom), 4'($urandom), 0, 0, 8'h00, 8'h00);
            wait_done(0, 4000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
